// File: rtl/l1_icache.sv
// Direct-mapped, read-only L1 instruction cache. Serves 32-bit fetches, fills whole
// lines in one beat from the LLC read port, supports fence.i flush and hit/miss counters.
module l1_icache #(
  parameter int unsigned LINE_COUNT     = 32,
  parameter int unsigned BYTES_PER_LINE = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [63:0]  fetch_addr,
  input  logic         fetch_valid,
  output logic         fetch_ready,
  output logic [31:0]  fetch_instr,
  output logic         fetch_instr_valid,
  output logic         fetch_misaligned,
  input  logic         flush,
  output logic [63:0]  llc_r_addr,
  output logic         llc_r_addr_valid,
  input  logic [511:0] llc_r_data,
  input  logic         llc_r_data_valid,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int unsigned INDEX_SIZE  = $clog2(LINE_COUNT);
  localparam int unsigned OFFSET_SIZE = $clog2(BYTES_PER_LINE);
  localparam int unsigned TAG_SIZE    = 64 - INDEX_SIZE - OFFSET_SIZE;
  localparam int unsigned WORD_SIZE   = OFFSET_SIZE - 2;
  localparam int unsigned LINE_BITS   = BYTES_PER_LINE * 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOOKUP  = 2'd1,
    S_MISS    = 2'd2,
    S_RESPOND = 2'd3
  } state_e;

  state_e                  state_q;
  logic [63:0]             addr_q;
  logic [LINE_COUNT-1:0]   valid_q;
  logic                    req_q;
  logic [31:0]             hit_count_q;
  logic [31:0]             miss_count_q;
  logic [31:0]             hit_count_d;
  logic [31:0]             miss_count_d;

  logic [TAG_SIZE-1:0]     tag_mem  [LINE_COUNT];
  logic [LINE_BITS-1:0]    data_mem [LINE_COUNT];

  logic [TAG_SIZE-1:0]     req_tag;
  logic [INDEX_SIZE-1:0]   req_index;
  logic [WORD_SIZE-1:0]    req_word;
  logic                    aligned;
  logic                    tag_match;
  logic                    lookup_hit;
  logic                    accept;
  logic                    fill_en;
  logic [LINE_BITS-1:0]    rd_line;
  logic [31:0]             rd_word;

  // Field split of the latched request address.
  assign req_tag   = addr_q[63 -: TAG_SIZE];
  assign req_index = addr_q[OFFSET_SIZE +: INDEX_SIZE];
  assign req_word  = addr_q[2 +: WORD_SIZE];
  assign aligned   = (addr_q[1:0] == 2'b00);

  assign tag_match  = valid_q[req_index] && (tag_mem[req_index] == req_tag);
  assign lookup_hit = (state_q == S_LOOKUP) && aligned && tag_match;
  assign rd_line    = data_mem[req_index];
  assign rd_word    = rd_line[{req_word, 5'b00000} +: 32];

  // Flush blocks new requests and suppresses any response in the same cycle.
  assign fetch_ready       = !flush && ((state_q == S_IDLE) || lookup_hit);
  assign accept            = fetch_valid && fetch_ready;
  assign fetch_instr_valid = !flush && (lookup_hit || (state_q == S_RESPOND));
  assign fetch_instr       = fetch_instr_valid ? rd_word : 32'd0;
  assign fetch_misaligned  = !flush && (state_q == S_LOOKUP) && !aligned;

  assign llc_r_addr       = {req_tag, req_index, {OFFSET_SIZE{1'b0}}};
  assign llc_r_addr_valid = req_q;

  assign fill_en = (state_q == S_MISS) && llc_r_data_valid && !flush;

  assign hit_count_d  = (hit_count_q  == 32'hFFFF_FFFF) ? hit_count_q  : hit_count_q  + 32'd1;
  assign miss_count_d = (miss_count_q == 32'hFFFF_FFFF) ? miss_count_q : miss_count_q + 32'd1;
  assign hit_count    = hit_count_q;
  assign miss_count   = miss_count_q;

  // Control FSM, valid bits, LLC request and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= 64'd0;
      valid_q      <= '0;
      req_q        <= 1'b0;
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
    end else if (flush) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_q  <= fetch_addr;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (!aligned) begin
            state_q <= S_IDLE;
          end else if (tag_match) begin
            hit_count_q <= hit_count_d;
            if (accept) begin
              addr_q <= fetch_addr;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            miss_count_q <= miss_count_d;
            req_q        <= 1'b1;
            state_q      <= S_MISS;
          end
        end
        S_MISS: begin
          if (llc_r_data_valid) begin
            valid_q[req_index] <= 1'b1;
            req_q              <= 1'b0;
            state_q            <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Tag and data arrays need no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (!reset && fill_en) begin
      tag_mem[req_index]  <= req_tag;
      data_mem[req_index] <= llc_r_data;
    end
  end

endmodule

// File: tb/tb_l1_icache.sv
// Bench for l1_icache: directed table of fetches, hand-written stream/flush/saturation
// sequences, then random traffic, all checked cycle by cycle against a request-level model.
module tb_l1_icache;

  localparam int unsigned LINES = 32;
  localparam int K_MISS = 0;
  localparam int K_HIT  = 1;
  localparam int K_MIS  = 2;
  localparam int K_NONE = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  fetch_addr;
  logic         fetch_valid;
  logic         fetch_ready;
  logic [31:0]  fetch_instr;
  logic         fetch_instr_valid;
  logic         fetch_misaligned;
  logic         flush;
  logic [63:0]  llc_r_addr;
  logic         llc_r_addr_valid;
  logic [511:0] llc_r_data = '0;
  logic         llc_r_data_valid = 1'b0;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int n_checks = 0;
  int n_fail   = 0;
  int llc_lat  = 10;
  int llc_cnt  = 0;

  always #5 clk = ~clk;

  l1_icache dut (
    .clk               (clk),
    .reset             (reset),
    .fetch_addr        (fetch_addr),
    .fetch_valid       (fetch_valid),
    .fetch_ready       (fetch_ready),
    .fetch_instr       (fetch_instr),
    .fetch_instr_valid (fetch_instr_valid),
    .fetch_misaligned  (fetch_misaligned),
    .flush             (flush),
    .llc_r_addr        (llc_r_addr),
    .llc_r_addr_valid  (llc_r_addr_valid),
    .llc_r_data        (llc_r_data),
    .llc_r_data_valid  (llc_r_data_valid),
    .hit_count         (hit_count),
    .miss_count        (miss_count)
  );

  // Backing memory contents: a fixed hash of the word address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [63:0] h;
    if (a == 64'h1004) return 32'hDEAD_BEEF;
    h = (a >> 2) * 64'h9E37_79B9_7F4A_7C15;
    return h[63:32] ^ h[31:0];
  endfunction

  function automatic logic [511:0] mem_line(input logic [63:0] la);
    logic [511:0] l;
    l = '0;
    for (int w = 0; w < 16; w++) l[32*w +: 32] = mem_word(la + 64'(4 * w));
    return l;
  endfunction

  // LLC: answers a held request after llc_lat cycles of addr_valid.
  always @(negedge clk) begin
    llc_r_data_valid = 1'b0;
    if (reset || !llc_r_addr_valid) begin
      llc_cnt = 0;
    end else begin
      llc_cnt++;
      if (llc_cnt >= llc_lat) begin
        llc_r_data_valid = 1'b1;
        llc_r_data       = mem_line(llc_r_addr);
        llc_cnt          = 0;
      end
    end
  end

  // Request-level model of the cache.
  logic        m_valid [LINES];
  logic [63:0] m_tag   [LINES];
  logic [31:0] m_hit, m_miss;
  logic [63:0] req_addr;
  bit          lk, waiting, resp;

  bit          obs_acc, obs_iv, obs_mis, obs_av;
  logic [31:0] obs_instr;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(LINES); i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 64'd0;
    end
    m_hit = 32'd0; m_miss = 32'd0; req_addr = 64'd0;
    lk = 0; waiting = 0; resp = 0;
  endtask

  task automatic step();
    int          ix;
    bit          al, hit, idle, lk_n, resp_n;
    logic        ex_ready, ex_iv, ex_mis;
    logic [31:0] ex_instr;
    obs_acc   = fetch_valid && fetch_ready;
    obs_iv    = fetch_instr_valid;
    obs_mis   = fetch_misaligned;
    obs_av    = llc_r_addr_valid;
    obs_instr = fetch_instr;
    if (reset) begin
      model_reset();
      return;
    end
    ix   = int'((req_addr / 64'd64) % 64'd32);
    al   = (req_addr % 64'd4) == 64'd0;
    hit  = m_valid[ix] && (m_tag[ix] == req_addr / 64'd2048);
    idle = !lk && !waiting && !resp;
    ex_ready = !flush && (idle || (lk && al && hit));
    ex_iv    = !flush && ((lk && al && hit) || resp);
    ex_instr = ex_iv ? mem_word(req_addr) : 32'd0;
    ex_mis   = !flush && lk && !al;
    chk("fetch_ready", 64'(fetch_ready), 64'(ex_ready));
    chk("instr_valid", 64'(fetch_instr_valid), 64'(ex_iv));
    chk("instr", 64'(fetch_instr), 64'(ex_instr));
    chk("misaligned", 64'(fetch_misaligned), 64'(ex_mis));
    chk("llc_addr_valid", 64'(llc_r_addr_valid), 64'(waiting));
    if (waiting) chk("llc_addr", llc_r_addr, req_addr - req_addr % 64'd64);
    chk("hit_count", 64'(hit_count), 64'(m_hit));
    chk("miss_count", 64'(miss_count), 64'(m_miss));
    if (flush) begin
      for (int i = 0; i < int'(LINES); i++) m_valid[i] = 1'b0;
      lk = 0; waiting = 0; resp = 0;
    end else begin
      resp_n = 0;
      lk_n   = 0;
      if (waiting && llc_r_data_valid) begin
        m_valid[ix] = 1'b1;
        m_tag[ix]   = req_addr / 64'd2048;
        waiting     = 0;
        resp_n      = 1;
      end
      if (lk && al) begin
        if (hit) begin
          if (m_hit != 32'hFFFF_FFFF) m_hit++;
        end else begin
          if (m_miss != 32'hFFFF_FFFF) m_miss++;
          waiting = 1;
        end
      end
      if (obs_acc) begin
        req_addr = fetch_addr;
        lk_n     = 1;
      end
      resp = resp_n;
      lk   = lk_n;
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
    step();
    @(posedge clk); #1;
  endtask

  task automatic wait_accept(input logic [63:0] a, output bit ok);
    fetch_valid = 1'b1;
    fetch_addr  = a;
    ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      if (obs_acc) ok = 1;
    end
    fetch_valid = 1'b0;
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_fetch(input logic [63:0] a, output int kind, output logic [31:0] word,
                          output int lat);
    bit ok, saw_av, done;
    kind = K_NONE; word = 32'd0; lat = 0;
    wait_accept(a, ok);
    if (!ok) return;
    saw_av = 0; done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      tick();
      lat++;
      if (obs_av) saw_av = 1;
      if (obs_iv || obs_mis) done = 1;
    end
    if (done) kind = obs_mis ? K_MIS : (saw_av ? K_MISS : K_HIT);
    word = obs_instr;
  endtask

  task automatic run_stream();
    logic [63:0] sa [3];
    int i, n_iv, first, last;
    bit saw_av;
    sa[0] = 64'h1008; sa[1] = 64'h100C; sa[2] = 64'h1000;
    i = 0; n_iv = 0; first = -1; last = -1; saw_av = 0;
    fetch_valid = 1'b1;
    fetch_addr  = sa[0];
    for (int c = 0; c < 20; c++) begin
      tick();
      if (obs_av) saw_av = 1;
      if (obs_iv) begin
        if (n_iv < 3) chk("stream_word", 64'(obs_instr), 64'(mem_word(sa[n_iv])));
        n_iv++;
        if (first < 0) first = c;
        last = c;
      end
      if (obs_acc) begin
        i++;
        if (i < 3) fetch_addr = sa[i];
        else fetch_valid = 1'b0;
      end
    end
    fetch_valid = 1'b0;
    chk("stream_count", 64'(n_iv), 64'd3);
    chk("stream_first_latency", 64'(first), 64'd1);
    chk("stream_consecutive", 64'(last - first), 64'd2);
    chk("stream_no_llc", 64'(saw_av), 64'd0);
    chk("stream_hits", 64'(hit_count), 64'd3);
  endtask

  task automatic run_flush();
    bit ok, saw_iv;
    int n_av;
    wait_accept(64'h2000, ok);
    n_av = 0;
    for (int c = 0; c < 20 && n_av < 2; c++) begin
      tick();
      if (obs_av) n_av++;
    end
    flush       = 1'b1;
    fetch_valid = 1'b1;
    fetch_addr  = 64'h1000;
    tick();
    chk("flush_cycle_av", 64'(obs_av), 64'd1);
    chk("flush_no_accept", 64'(obs_acc), 64'd0);
    flush       = 1'b0;
    fetch_valid = 1'b0;
    tick();
    chk("flush_av_dropped", 64'(obs_av), 64'd0);
    saw_iv = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (obs_iv) saw_iv = 1;
    end
    chk("flush_no_instr", 64'(saw_iv), 64'd0);
  endtask

  typedef struct {
    logic [63:0] addr;
    int          kind;
    logic [31:0] word;
    int          lat;
    logic [31:0] hits;
    logic [31:0] misses;
  } vec_t;

  vec_t vt [6];

  initial begin
    int          kind, lat;
    logic [31:0] word;
    logic [63:0] ra;
    bit          ok;

    vt[0] = '{64'h1004, K_MISS, 32'hDEAD_BEEF,       12, 32'd0, 32'd1};
    vt[1] = '{64'h1000, K_HIT,  mem_word(64'h1000),  1,  32'd4, 32'd1};
    vt[2] = '{64'h1800, K_MISS, mem_word(64'h1800),  12, 32'd4, 32'd2};
    vt[3] = '{64'h1000, K_MISS, mem_word(64'h1000),  12, 32'd4, 32'd3};
    vt[4] = '{64'h1000, K_MISS, mem_word(64'h1000),  12, 32'd4, 32'd5};
    vt[5] = '{64'h1002, K_MIS,  32'd0,               1,  32'd4, 32'd5};

    reset = 1'b1; fetch_valid = 1'b0; fetch_addr = 64'd0; flush = 1'b0;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_ready", 64'(obs_acc || fetch_ready), 64'd1);

    for (int i = 0; i < 6; i++) begin
      if (i == 1) run_stream();
      if (i == 4) run_flush();
      do_fetch(vt[i].addr, kind, word, lat);
      chk($sformatf("vec%0d_kind", i), 64'(kind), 64'(vt[i].kind));
      chk($sformatf("vec%0d_word", i), 64'(word), 64'(vt[i].word));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].lat));
      tick();
      chk($sformatf("vec%0d_hits", i), 64'(hit_count), 64'(vt[i].hits));
      chk($sformatf("vec%0d_misses", i), 64'(miss_count), 64'(vt[i].misses));
    end

    // Saturation: preload the hit counter, then hit the resident 0x1000 line.
    dut.hit_count_q = 32'hFFFF_FFFF;
    m_hit = 32'hFFFF_FFFF;
    do_fetch(64'h1000, kind, word, lat);
    chk("sat_kind", 64'(kind), 64'(K_HIT));
    tick();
    chk("sat_hit_count", 64'(hit_count), 64'hFFFF_FFFF);
    chk("sat_miss_count", 64'(miss_count), 64'd5);

    // Reset while a miss is outstanding.
    wait_accept(64'h3000, ok);
    tick();
    tick();
    chk("rst_mid_av_before", 64'(obs_av), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("rst_mid_av_after", 64'(obs_av), 64'd0);
    chk("rst_mid_counters", 64'({hit_count, miss_count}), 64'd0);

    for (int r = 0; r < 3000; r++) begin
      if (r % 50 == 0) llc_lat = int'($urandom_range(1, 6));
      ra = {51'd0, 2'($urandom_range(0, 3)), 2'b00, 3'($urandom_range(0, 7)),
            4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 99) < 5) ra[63:32] = $urandom;
      if ($urandom_range(0, 99) < 8) ra[1:0] = 2'($urandom_range(1, 3));
      fetch_addr  = ra;
      fetch_valid = ($urandom_range(0, 99) < 60);
      flush       = ($urandom_range(0, 99) < 3);
      tick();
    end
    fetch_valid = 1'b0;
    flush       = 1'b0;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
